phys_free_list: RTL and testbench

Circular FIFO of unallocated physical register tags, sitting directly upstream of the architectural register file / rename table in the rename stage. On each renamed instruction that writes a non-x0 destination it supplies the new physical tag that the rename table installs as `rd_tag`. At retirement it takes back the superseded tag that the rename table previously returned as `rd_old_tag`. Reset state matches the rename table's identity mapping: architectural regs own pregs 0..NUM_AREG-1; pregs NUM_AREG..NUM_PREG-1 are free.

---
 rtl/phys_free_list.sv | 110 +++++++++++
 tb/tb_phys_free_list.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/phys_free_list.sv
`default_nettype none
// ============================================================================
//  Module   : phys_free_list
//  Brief    : Circular FIFO of unallocated physical register tags for the
//             rename stage. Hands out one tag per cycle at the head and takes
//             back superseded tags at the tail on retirement.
//  Revision : 1.0 - initial release
// ============================================================================
module phys_free_list #(
  parameter int PREG_WIDTH = 6,
  parameter int NUM_AREG   = 32,
  parameter int NUM_PREG   = 64,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,         // asynchronous, active-low
  input  logic                  alloc_req,
  output logic                  alloc_gnt,
  output logic [PREG_WIDTH-1:0] alloc_tag,
  output logic                  free_empty,
  input  logic                  rel_valid,
  input  logic [PREG_WIDTH-1:0] rel_tag,
  output logic [CNT_WIDTH-1:0]  free_count,
  output logic                  rel_err
);

  localparam int DEPTH = NUM_PREG - NUM_AREG;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PREG_WIDTH-1:0] tags_q [DEPTH];
  logic [PREG_WIDTH-1:0] tags_d [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  rel_err_q, rel_err_d;

  logic w_empty;
  logic w_full;
  logic w_rel_live;
  logic w_rel_acc;
  logic w_rel_drop;

  // Status flags and handshake decode; a release into a full list still fits
  // when the head slot is vacated on the same edge.
  always_comb begin
    w_empty    = (count_q == '0);
    w_full     = (count_q == CNT_WIDTH'(DEPTH));
    alloc_gnt  = alloc_req & ~w_empty;
    w_rel_live = rel_valid & (rel_tag != '0);  // preg 0 is hardwired x0
    w_rel_acc  = w_rel_live & (~w_full | alloc_gnt);
    w_rel_drop = w_rel_live & w_full & ~alloc_gnt;
  end

  // Next-state: pointer advance, tail write, occupancy and sticky error.
  always_comb begin
    tags_d    = tags_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    rel_err_d = rel_err_q;

    if (alloc_gnt) begin
      head_d = head_q + PTR_W'(1);
    end

    if (w_rel_acc) begin
      tags_d[tail_q] = rel_tag;
      tail_d         = tail_q + PTR_W'(1);
    end

    if (w_rel_drop) begin
      rel_err_d = 1'b1;
    end

    case ({w_rel_acc, alloc_gnt})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset reloads the identity mapping's spare pregs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tags_q[i] <= PREG_WIDTH'(NUM_AREG + i);
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= CNT_WIDTH'(DEPTH);
      rel_err_q <= 1'b0;
    end else begin
      tags_q    <= tags_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rel_err_q <= rel_err_d;
    end
  end

  // Outputs come straight from state; the tag is meaningless while empty.
  always_comb begin
    alloc_tag  = tags_q[head_q];
    free_empty = w_empty;
    free_count = count_q;
    rel_err    = rel_err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_phys_free_list.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phys_free_list
//  Brief    : Self-checking bench for phys_free_list. Directed stimulus pushes
//             expected granted tags into a queue; a monitor pops and compares
//             each time the DUT grants. Status outputs are checked inline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_phys_free_list;

  localparam int PREG_WIDTH = 6;
  localparam int CNT_WIDTH  = 6;

  logic                  clk;
  logic                  rst;
  logic                  alloc_req;
  logic                  alloc_gnt;
  logic [PREG_WIDTH-1:0] alloc_tag;
  logic                  free_empty;
  logic                  rel_valid;
  logic [PREG_WIDTH-1:0] rel_tag;
  logic [CNT_WIDTH-1:0]  free_count;
  logic                  rel_err;

  int n_cmp;
  int n_fail;
  int exp_q[$];

  phys_free_list #(
    .PREG_WIDTH(PREG_WIDTH),
    .NUM_AREG  (32),
    .NUM_PREG  (64),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .alloc_req (alloc_req),
    .alloc_gnt (alloc_gnt),
    .alloc_tag (alloc_tag),
    .free_empty(free_empty),
    .rel_valid (rel_valid),
    .rel_tag   (rel_tag),
    .free_count(free_count),
    .rel_err   (rel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every grant seen at the falling edge must match the queue head.
  always @(negedge clk) begin
    if (alloc_gnt === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_grant: got tag %0d expected no grant (t=%0t)",
                 alloc_tag, $time);
      end else begin
        chk("grant_tag", int'(alloc_tag), exp_q.pop_front());
      end
    end
  end

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic step(input logic req, input logic rv, input int rt);
    @(posedge clk);
    #1;
    alloc_req = req;
    rel_valid = rv;
    rel_tag   = PREG_WIDTH'(rt);
    @(negedge clk);
  endtask

  task automatic grant(input int tag);
    exp_q.push_back(tag);
    step(1'b1, 1'b0, 0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    alloc_req = 1'b0;
    rel_valid = 1'b0;
    rel_tag   = '0;
    rst       = 1'b0;
    #1;
    chk("rst_alloc_tag", int'(alloc_tag), 32);
    chk("rst_free_count", int'(free_count), 32);
    chk("rst_free_empty", int'(free_empty), 0);
    chk("rst_rel_err", int'(rel_err), 0);
    chk("rst_alloc_gnt", int'(alloc_gnt), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b0;
    alloc_req = 1'b0;
    rel_valid = 1'b0;
    rel_tag   = '0;

    // Full drain: 32..63 in order, then empty.
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      grant(32 + i);
      chk("drain_gnt", int'(alloc_gnt), 1);
    end
    step(1'b1, 1'b0, 0);
    chk("empty_flag", int'(free_empty), 1);
    chk("empty_gnt", int'(alloc_gnt), 0);
    chk("empty_count", int'(free_count), 0);

    // Release into empty list: no bypass, then FIFO order 5, 9.
    step(1'b1, 1'b1, 5);
    chk("nobypass_gnt", int'(alloc_gnt), 0);
    exp_q.push_back(5);
    step(1'b1, 1'b1, 9);
    chk("refill_count", int'(free_count), 1);
    grant(9);
    step(1'b0, 1'b0, 0);
    chk("refill_end_count", int'(free_count), 0);
    chk("refill_end_empty", int'(free_empty), 1);

    // Tag 0 ignored while empty.
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    chk("x0_empty_count", int'(free_count), 0);
    chk("x0_empty_err", int'(rel_err), 0);

    // Release into full list with no grant is dropped and sticky.
    apply_reset();
    step(1'b0, 1'b1, 7);
    chk("drop_err_same_cycle", int'(rel_err), 0);
    step(1'b0, 1'b0, 0);
    chk("drop_err", int'(rel_err), 1);
    chk("drop_count", int'(free_count), 32);
    step(1'b0, 1'b0, 0);
    chk("drop_err_sticky", int'(rel_err), 1);
    chk("drop_tag_unchanged", int'(alloc_tag), 32);

    // Full list with simultaneous grant accepts the release.
    apply_reset();
    exp_q.push_back(32);
    step(1'b1, 1'b1, 7);
    step(1'b0, 1'b0, 0);
    chk("swap_err", int'(rel_err), 0);
    chk("swap_count", int'(free_count), 32);
    chk("swap_next_tag", int'(alloc_tag), 33);

    // Tag 0 ignored while full: no error, no change.
    apply_reset();
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    chk("x0_full_err", int'(rel_err), 0);
    chk("x0_full_count", int'(free_count), 32);
    chk("x0_full_tag", int'(alloc_tag), 32);

    // Wrap: drain 31, release 11,12,13, allocate 63 then 11,12,13.
    apply_reset();
    for (int i = 0; i < 31; i++) grant(32 + i);
    step(1'b0, 1'b1, 11);
    chk("wrap_count_31", int'(free_count), 1);
    step(1'b0, 1'b1, 12);
    step(1'b0, 1'b1, 13);
    step(1'b0, 1'b0, 0);
    chk("wrap_count_4", int'(free_count), 4);
    grant(63);
    grant(11);
    grant(12);
    grant(13);
    step(1'b1, 1'b0, 0);
    chk("wrap_empty_gnt", int'(alloc_gnt), 0);
    chk("wrap_empty_count", int'(free_count), 0);

    // Asynchronous reset mid-burst, with rel_err set beforehand.
    apply_reset();
    step(1'b0, 1'b1, 7);
    grant(32);
    chk("pre_burst_err", int'(rel_err), 1);
    grant(33);
    grant(34);
    @(posedge clk);
    #1;
    alloc_req = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("async_alloc_tag", int'(alloc_tag), 32);
    chk("async_free_count", int'(free_count), 32);
    chk("async_free_empty", int'(free_empty), 0);
    chk("async_rel_err", int'(rel_err), 0);
    chk("async_gnt_follows_req", int'(alloc_gnt), 1);
    alloc_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    grant(32);
    grant(33);
    step(1'b0, 1'b0, 0);
    chk("resume_count", int'(free_count), 30);

    step(1'b0, 1'b0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
